// File: rtl/mem_ctrl_defs.sv
// Shared definitions for controllers driving the 4x3 asynchronous memory:
// FSM state and self-test pass encodings plus the test-pattern helpers.
package mem_ctrl_defs;

    localparam int ROW_W  = 2;
    localparam int DATA_W = 3;

    localparam logic [ROW_W-1:0] ROW_LAST = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_W_SETUP  = 3'd1,
        ST_W_STROBE = 3'd2,
        ST_W_HOLD   = 3'd3,
        ST_R_DRIVE  = 3'd4,
        ST_R_SAMPLE = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

    // Bit 0 set marks a read pass, bit 1 set marks the inverted pattern.
    typedef enum logic [1:0] {
        PASS_WR_P = 2'd0,
        PASS_RD_P = 2'd1,
        PASS_WR_N = 2'd2,
        PASS_RD_N = 2'd3
    } pass_e;

    function automatic logic [DATA_W-1:0] pattern(input logic [ROW_W-1:0] a);
        return {a[0], a[1], ~a[0]};
    endfunction

    function automatic logic pass_is_write(input pass_e p);
        return ~p[0];
    endfunction

    function automatic logic [DATA_W-1:0] pass_data(input pass_e p, input logic [ROW_W-1:0] a);
        return pattern(a) ^ {DATA_W{p[1]}};
    endfunction

endpackage

// File: rtl/bist_seq.sv
// Self-test sequencer: row and pass counters plus the pattern generator.
// The next_* outputs describe the access the FSM is about to launch.
module bist_seq
    import mem_ctrl_defs::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              advance_i,
    output logic [ROW_W-1:0]  row_o,
    output logic [DATA_W-1:0] exp_o,
    output logic              last_o,
    output logic [ROW_W-1:0]  next_row_o,
    output logic [DATA_W-1:0] next_data_o,
    output logic              next_write_o
);

    logic [ROW_W-1:0] row_q, row_d;
    pass_e            pass_q, pass_d;

    always_comb begin
        row_d  = row_q;
        pass_d = pass_q;
        if (start_i) begin
            row_d  = '0;
            pass_d = PASS_WR_P;
        end else if (advance_i) begin
            row_d = row_q + 2'd1;
            if (row_q == ROW_LAST) begin
                pass_d = pass_e'(pass_q + 2'd1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q  <= '0;
            pass_q <= PASS_WR_P;
        end else begin
            row_q  <= row_d;
            pass_q <= pass_d;
        end
    end

    assign row_o        = row_q;
    assign exp_o        = pass_data(pass_q, row_q);
    assign last_o       = (pass_q == PASS_RD_N) && (row_q == ROW_LAST);
    assign next_row_o   = row_d;
    assign next_data_o  = pass_data(pass_d, row_d);
    assign next_write_o = pass_is_write(pass_d);

endmodule

// File: rtl/mem_ctrl_4_3.sv
// Host/self-test controller for a 4x3 asynchronous memory with separate
// setup/strobe/hold write timing and a multi-cycle read window.
module mem_ctrl_4_3
    import mem_ctrl_defs::*;
#(
    parameter int STROBE_CYC = 1,
    parameter int READ_CYC   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ROW_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    input  logic              bist_start,
    output logic              bist_done,
    output logic              bist_fail,
    output logic [ROW_W-1:0]  fail_addr,
    output logic [ROW_W-1:0]  mem_a,
    output logic [DATA_W-1:0] mem_i,
    output logic              mem_cs,
    output logic              mem_rd,
    output logic              mem_oe,
    input  logic [DATA_W-1:0] mem_o
);

    localparam logic [1:0] STROBE_LAST = 2'(STROBE_CYC - 1);
    localparam logic [1:0] DRIVE_LAST  = 2'(READ_CYC - 2);
    // A single-cycle read has no drive phase and goes straight to sampling.
    localparam state_e     READ_ENTRY  = (READ_CYC == 1) ? ST_R_SAMPLE : ST_R_DRIVE;

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              bist_q, bist_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              fail_q, fail_d;
    logic [ROW_W-1:0]  fail_addr_q, fail_addr_d;
    logic [ROW_W-1:0]  mem_a_q, mem_a_d;
    logic [DATA_W-1:0] mem_i_q, mem_i_d;

    logic              seq_start, seq_adv, seq_last, seq_next_write;
    logic [ROW_W-1:0]  seq_row, seq_next_row;
    logic [DATA_W-1:0] seq_exp, seq_next_data;
    logic              rd_miss;

    assign seq_start = (state_q == ST_IDLE) && bist_start;
    assign seq_adv   = (state_q == ST_DONE) && bist_q && !seq_last;
    // Case inequality so an undriven or unknown bit counts as a failure.
    assign rd_miss   = (mem_o !== seq_exp);

    bist_seq u_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (seq_start),
        .advance_i    (seq_adv),
        .row_o        (seq_row),
        .exp_o        (seq_exp),
        .last_o       (seq_last),
        .next_row_o   (seq_next_row),
        .next_data_o  (seq_next_data),
        .next_write_o (seq_next_write)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bist_start) begin
                    state_d = ST_W_SETUP;
                end else if (req) begin
                    state_d = we ? ST_W_SETUP : READ_ENTRY;
                end
            end
            ST_W_SETUP:  state_d = ST_W_STROBE;
            ST_W_STROBE: if (cnt_q == STROBE_LAST) state_d = ST_W_HOLD;
            ST_W_HOLD:   state_d = ST_DONE;
            ST_R_DRIVE:  if (cnt_q == DRIVE_LAST) state_d = ST_R_SAMPLE;
            ST_R_SAMPLE: state_d = ST_DONE;
            ST_DONE: begin
                if (bist_q && !seq_last) begin
                    state_d = seq_next_write ? ST_W_SETUP : READ_ENTRY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default:     state_d = ST_IDLE;
        endcase
        cnt_d = (state_d == state_q) ? cnt_q + 2'd1 : 2'd0;
    end

    always_comb begin
        mem_cs = 1'b0;
        mem_rd = 1'b0;
        mem_oe = 1'b0;
        unique case (state_q)
            ST_W_STROBE: mem_cs = 1'b1;
            ST_R_DRIVE, ST_R_SAMPLE: begin
                mem_cs = 1'b1;
                mem_rd = 1'b1;
                mem_oe = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign ack       = (state_q == ST_DONE) && !bist_q;
    assign bist_done = (state_q == ST_DONE) && bist_q && seq_last;

    // Address/data only move on the edges that launch an access, when cs is low.
    always_comb begin
        bist_d      = bist_q;
        rdata_d     = rdata_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        mem_a_d     = mem_a_q;
        mem_i_d     = mem_i_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bist_start) begin
                    bist_d      = 1'b1;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    mem_a_d     = seq_next_row;
                    mem_i_d     = seq_next_data;
                end else if (req) begin
                    mem_a_d = addr;
                    if (we) begin
                        mem_i_d = wdata;
                    end
                end
            end
            ST_R_SAMPLE: begin
                if (!bist_q) begin
                    rdata_d = mem_o;
                end else if (rd_miss) begin
                    fail_d = 1'b1;
                    if (!fail_q) begin
                        fail_addr_d = seq_row;
                    end
                end
            end
            ST_DONE: begin
                if (bist_q) begin
                    if (seq_last) begin
                        bist_d = 1'b0;
                    end else begin
                        mem_a_d = seq_next_row;
                        mem_i_d = seq_next_data;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bist_q      <= 1'b0;
            rdata_q     <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            mem_a_q     <= '0;
            mem_i_q     <= '0;
        end else begin
            bist_q      <= bist_d;
            rdata_q     <= rdata_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            mem_a_q     <= mem_a_d;
            mem_i_q     <= mem_i_d;
        end
    end

    assign rdata     = rdata_q;
    assign bist_fail = fail_q;
    assign fail_addr = fail_addr_q;
    assign mem_a     = mem_a_q;
    assign mem_i     = mem_i_q;

endmodule
